// File: rtl/structures.sv
// Shared types for the MEM-stage controller: memory op encoding, FSM states,
// lane geometry and small op-classification helpers.
package structures;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;
  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LBU  = 4'd2,
    MEM_LH   = 4'd3,
    MEM_LHU  = 4'd4,
    MEM_LW   = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_R = 2'd2,
    ST_RESP   = 2'd3
  } mem_state_t;

  function automatic logic op_is_load(input mem_op_t op);
    logic r;
    case (op)
      MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW: r = 1'b1;
      default:                                  r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic op_is_store(input mem_op_t op);
    logic r;
    case (op)
      MEM_SB, MEM_SH, MEM_SW: r = 1'b1;
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

  // Natural alignment: words on 4-byte, halfwords on 2-byte boundaries.
  function automatic logic op_misaligned(input mem_op_t op, input logic [1:0] lane);
    logic r;
    case (op)
      MEM_LW, MEM_SW:          r = (lane != 2'b00);
      MEM_LH, MEM_LHU, MEM_SH: r = lane[0];
      default:                 r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store byte enables / replicated write data,
// and load byte/halfword extraction with sign or zero extension.
module mem_lane_align
  import structures::*;
(
  input  mem_op_t           op,
  input  logic [1:0]        lane,
  input  logic [WORD_W-1:0] store_data,
  input  logic [WORD_W-1:0] rdata,
  output logic [BE_W-1:0]   be,
  output logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] load_data
);

  logic [BYTE_W-1:0] byte_s;
  logic [HALF_W-1:0] half_s;

  // Store byte enables and lane-replicated write data
  always_comb begin
    be    = 4'h0;
    wdata = store_data;
    case (op)
      MEM_SB: begin
        be    = 4'b0001 << lane;
        wdata = {4{store_data[BYTE_W-1:0]}};
      end
      MEM_SH: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[HALF_W-1:0]}};
      end
      MEM_SW, MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW: be = 4'hF;
      default: be = 4'h0;
    endcase
  end

  // Select the addressed byte and halfword from the read word
  always_comb begin
    byte_s = rdata[7:0];
    case (lane)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      2'd3:    byte_s = rdata[31:24];
      default: byte_s = rdata[7:0];
    endcase
    if (lane[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
  end

  // Extend the selected lane to a full register value
  always_comb begin
    load_data = 32'h0;
    case (op)
      MEM_LB:  load_data = {{(WORD_W-BYTE_W){byte_s[BYTE_W-1]}}, byte_s};
      MEM_LBU: load_data = {{(WORD_W-BYTE_W){1'b0}}, byte_s};
      MEM_LH:  load_data = {{(WORD_W-HALF_W){half_s[HALF_W-1]}}, half_s};
      MEM_LHU: load_data = {{(WORD_W-HALF_W){1'b0}}, half_s};
      MEM_LW:  load_data = rdata;
      default: load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: one memory op at a time between EX/MEM and MEM/WB.
// Define MEM_ALIGN_CHECK_EN to trap misaligned LW/SW/LH/LHU/SH without a memory request.
module mem_stage_ctrl
  import structures::*;
#(
  parameter int ADDR_W    = 32,
  parameter int REG_IDX_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  mem_op_t              mem_op,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [WORD_W-1:0]    store_data,
  input  logic [REG_IDX_W-1:0] rd_in,
  input  logic                 wb_en_in,
  output logic                 out_valid,
  output logic [WORD_W-1:0]    result,
  output logic [REG_IDX_W-1:0] rd_out,
  output logic                 wb_en_out,
  output logic                 misalign,
  output logic                 dm_req,
  output logic                 dm_we,
  output logic [BE_W-1:0]      dm_be,
  output logic [ADDR_W-1:0]    dm_addr,
  output logic [WORD_W-1:0]    dm_wdata,
  input  logic                 dm_gnt,
  input  logic                 dm_rvalid,
  input  logic [WORD_W-1:0]    dm_rdata
);

  mem_state_t           state_q, state_d;
  mem_op_t              op_q, op_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [WORD_W-1:0]    sdata_q, sdata_d;
  logic [REG_IDX_W-1:0] rd_q, rd_d;
  logic                 wb_en_q, wb_en_d;
  logic                 mis_q, mis_d;
  logic [WORD_W-1:0]    result_q, result_d;

  logic                 misaligned_s;
  logic                 pass_s;
  logic [BE_W-1:0]      be_s;
  logic [WORD_W-1:0]    wdata_s;
  logic [WORD_W-1:0]    load_data_s;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned_s = op_misaligned(mem_op, addr[1:0]);
`else
  assign misaligned_s = 1'b0;
`endif

  // Unknown encodings are treated like NONE so they can never reach memory.
  assign pass_s = ~op_is_load(mem_op) & ~op_is_store(mem_op);

  mem_lane_align u_lane (
    .op         (op_q),
    .lane       (addr_q[1:0]),
    .store_data (sdata_q),
    .rdata      (dm_rdata),
    .be         (be_s),
    .wdata      (wdata_s),
    .load_data  (load_data_s)
  );

  // Next-state and captured-operation logic
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    sdata_d  = sdata_q;
    rd_d     = rd_q;
    wb_en_d  = wb_en_q;
    mis_d    = mis_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d     = mem_op;
          addr_d   = addr;
          sdata_d  = store_data;
          rd_d     = rd_in;
          mis_d    = misaligned_s;
          wb_en_d  = wb_en_in & ~op_is_store(mem_op) & ~misaligned_s;
          result_d = (pass_s & ~misaligned_s) ? WORD_W'(addr) : 32'h0;
          state_d  = (pass_s | misaligned_s) ? ST_RESP : ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (dm_gnt) begin
          state_d = op_is_store(op_q) ? ST_RESP : ST_WAIT_R;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT_R: begin
        if (dm_rvalid) begin
          result_d = load_data_s;
          state_d  = ST_RESP;
        end else begin
          state_d = ST_WAIT_R;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and operation registers; reset abandons any in-flight access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= MEM_NONE;
      addr_q   <= {ADDR_W{1'b0}};
      sdata_q  <= 32'h0;
      rd_q     <= {REG_IDX_W{1'b0}};
      wb_en_q  <= 1'b0;
      mis_q    <= 1'b0;
      result_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      sdata_q  <= sdata_d;
      rd_q     <= rd_d;
      wb_en_q  <= wb_en_d;
      mis_q    <= mis_d;
      result_q <= result_d;
    end
  end

  // in_ready is masked by rst_n so every output reads 0 while reset is held.
  assign in_ready  = rst_n & (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_RESP);
  assign result    = result_q;
  assign rd_out    = rd_q;
  assign wb_en_out = wb_en_q;
  assign misalign  = mis_q;

  assign dm_req   = (state_q == ST_REQ);
  assign dm_we    = dm_req & op_is_store(op_q);
  assign dm_be    = dm_req ? be_s : 4'h0;
  assign dm_addr  = dm_req ? {addr_q[ADDR_W-1:2], 2'b00} : {ADDR_W{1'b0}};
  assign dm_wdata = dm_we ? wdata_s : 32'h0;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed cases plus randomized ops
// against a timeline/arithmetic reference model.
module tb_mem_stage_ctrl;
  import structures::*;

  localparam int ADDR_W    = 32;
  localparam int REG_IDX_W = 5;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  mem_op_t              mem_op;
  logic [ADDR_W-1:0]    addr;
  logic [31:0]          store_data;
  logic [REG_IDX_W-1:0] rd_in;
  logic                 wb_en_in;
  logic                 out_valid;
  logic [31:0]          result;
  logic [REG_IDX_W-1:0] rd_out;
  logic                 wb_en_out;
  logic                 misalign;
  logic                 dm_req;
  logic                 dm_we;
  logic [3:0]           dm_be;
  logic [ADDR_W-1:0]    dm_addr;
  logic [31:0]          dm_wdata;
  logic                 dm_gnt;
  logic                 dm_rvalid;
  logic [31:0]          dm_rdata;

  mem_stage_ctrl #(.ADDR_W(ADDR_W), .REG_IDX_W(REG_IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mem_op(mem_op), .addr(addr), .store_data(store_data), .rd_in(rd_in),
    .wb_en_in(wb_en_in), .out_valid(out_valid), .result(result), .rd_out(rd_out),
    .wb_en_out(wb_en_out), .misalign(misalign), .dm_req(dm_req), .dm_we(dm_we),
    .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Expected transaction, as seen from the cycle of acceptance (k = 0).
  logic        act;
  int          k;
  logic        has_req, has_rv, chk_result;
  int          k_req_last, k_rv, k_ov;
  logic [31:0] e_addr, e_be, e_wdata, e_we, e_result, e_rd, e_wb, e_mis;
  logic        chk_en;
  logic        exp_req, exp_ov;

  logic [31:0] seen_result, seen_be, seen_addr, seen_wdata, seen_wb, seen_mis;
  int          seen_req_cnt;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, want);
  endtask

  // Reference model: memory request contents, writeback values and cycle timeline.
  task automatic model(input mem_op_t op, input logic [31:0] a, input logic [31:0] sd,
                       input logic [31:0] rdat, input logic wb, input int g, input int r);
    int lane;
    logic [31:0] b, h;
    logic load, store, mis;
    lane  = int'(a % 32'd4);
    load  = op inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW};
    store = op inside {MEM_SB, MEM_SH, MEM_SW};
    mis   = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    if ((op == MEM_LW || op == MEM_SW) && lane != 0) mis = 1'b1;
    if ((op == MEM_LH || op == MEM_LHU || op == MEM_SH) && (lane % 2) == 1) mis = 1'b1;
`endif
    e_mis  = 32'(mis);
    e_we   = 32'(store);
    e_addr = a & ~32'h3;
    e_wb   = 32'(wb && !store && !mis);
    b = (rdat >> (8 * lane)) & 32'hFF;
    h = (rdat >> (16 * (lane / 2))) & 32'hFFFF;
    case (op)
      MEM_LB:   e_result = (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
      MEM_LBU:  e_result = b;
      MEM_LH:   e_result = (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      MEM_LHU:  e_result = h;
      MEM_LW:   e_result = rdat;
      MEM_NONE: e_result = a;
      default:  e_result = 32'h0;
    endcase
    if (mis) e_result = 32'h0;
    case (op)
      MEM_SB:  begin e_be = 32'd1 << lane; e_wdata = (sd & 32'hFF) * 32'h0101_0101; end
      MEM_SH:  begin e_be = 32'd3 << (2 * (lane / 2)); e_wdata = (sd & 32'hFFFF) * 32'h0001_0001; end
      MEM_SW:  begin e_be = 32'hF; e_wdata = sd; end
      default: begin e_be = 32'hF; e_wdata = 32'h0; end
    endcase
    chk_result = !store || mis;
    has_req    = (load || store) && !mis;
    has_rv     = load && !mis;
    k_req_last = 1 + g;
    k_rv       = 2 + g + r;
    if (!has_req)   k_ov = 1;
    else if (store) k_ov = 2 + g;
    else            k_ov = 3 + g + r;
  endtask

  // Per-cycle comparison of DUT outputs against the model timeline.
  always @(negedge clk) begin
    if (chk_en) begin
      if (act && k >= 1) begin
        exp_req = has_req && (k <= k_req_last);
        exp_ov  = (k == k_ov);
        check("in_ready_busy", 32'(in_ready), 32'h0);
      end else begin
        exp_req = 1'b0;
        exp_ov  = 1'b0;
        check("in_ready_idle", 32'(in_ready), 32'h1);
      end
      check("dm_req", 32'(dm_req), 32'(exp_req));
      check("out_valid", 32'(out_valid), 32'(exp_ov));
      if (exp_req && dm_req) begin
        seen_req_cnt++;
        seen_be = 32'(dm_be); seen_addr = dm_addr; seen_wdata = dm_wdata;
        check("dm_we", 32'(dm_we), e_we);
        check("dm_be", 32'(dm_be), e_be);
        check("dm_addr", dm_addr, e_addr);
        if (e_we[0]) check("dm_wdata", dm_wdata, e_wdata);
      end
      if (exp_ov && out_valid) begin
        seen_result = result; seen_wb = 32'(wb_en_out); seen_mis = 32'(misalign);
        check("rd_out", 32'(rd_out), e_rd);
        check("wb_en_out", 32'(wb_en_out), e_wb);
        check("misalign", 32'(misalign), e_mis);
        if (chk_result) check("result", result, e_result);
      end
    end
  end

  task automatic run(input mem_op_t op, input logic [31:0] a, input logic [31:0] sd,
                     input logic [31:0] rdat, input logic [4:0] rd, input logic wb,
                     input int g, input int r, input logic stray);
    model(op, a, sd, rdat, wb, g, r);
    e_rd = 32'(rd);
    seen_req_cnt = 0;
    mem_op = op; addr = a; store_data = sd; rd_in = rd; wb_en_in = wb; in_valid = 1'b1;
    k = 0; act = 1'b1;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    mem_op     = mem_op_t'($urandom_range(0, 8));
    addr       = $urandom;
    store_data = $urandom;
    rd_in      = 5'($urandom);
    wb_en_in   = 1'($urandom);
    k = 1;
    while (k <= k_ov) begin
      dm_gnt    = has_req && (k == k_req_last);
      dm_rvalid = (has_rv && k == k_rv) || (stray && has_rv && g > 0 && k == 1);
      dm_rdata  = (has_rv && k == k_rv) ? rdat : $urandom;
      @(posedge clk); #1;
      k++;
    end
    dm_gnt = 1'b0; dm_rvalid = 1'b0; act = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic reset_mid(input int g, input int stop_k);
    model(MEM_LW, 32'h0000_0200, 32'h0, 32'hDEAD_BEEF, 1'b1, g, 4);
    e_rd = 32'd7;
    mem_op = MEM_LW; addr = 32'h200; store_data = 32'h0; rd_in = 5'd7; wb_en_in = 1'b1;
    in_valid = 1'b1; k = 0; act = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 1;
    while (k <= stop_k) begin
      dm_gnt = (k == k_req_last);
      @(posedge clk); #1;
      k++;
    end
    dm_gnt = 1'b0;
    @(negedge clk); #1;
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("rst_dm_req", 32'(dm_req), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check("rst_result", result, 32'h0);
    check("rst_wb_en", 32'(wb_en_out), 32'h0);
    act = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    idle(1);
    run(MEM_LW, 32'h0000_0300, 32'h0, 32'h1357_9BDF, 5'd9, 1'b1, 1, 1, 1'b0);
    check("post_rst_lw", seen_result, 32'h1357_9BDF);
  endtask

  initial begin
    in_valid = 1'b0; mem_op = MEM_NONE; addr = 32'h0; store_data = 32'h0; rd_in = 5'd0;
    wb_en_in = 1'b0; dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = 32'h0;
    act = 1'b0; k = 0; chk_en = 1'b0; rst_n = 1'b1;
    seen_req_cnt = 0;
    #2 rst_n = 1'b0;
    #1;
    check("reset_in_ready", 32'(in_ready), 32'h0);
    check("reset_out_valid", 32'(out_valid), 32'h0);
    check("reset_dm_req", 32'(dm_req), 32'h0);
    check("reset_result", result, 32'h0);
    check("reset_wb_misalign", {30'h0, wb_en_out, misalign}, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    idle(1);

    run(MEM_NONE, 32'h0000_1234, 32'h0, 32'h0, 5'd3, 1'b1, 0, 0, 1'b0);
    check("none_result", seen_result, 32'h0000_1234);
    check("none_no_req", 32'(seen_req_cnt), 32'h0);

    run(MEM_SB, 32'h0000_0103, 32'h0000_00AB, 32'h0, 5'd4, 1'b1, 2, 0, 1'b0);
    check("sb_be", seen_be, 32'h8);
    check("sb_addr", seen_addr, 32'h0000_0100);
    check("sb_wdata", seen_wdata, 32'hABAB_ABAB);
    check("sb_req_cycles", 32'(seen_req_cnt), 32'h3);
    check("sb_wb", seen_wb, 32'h0);

    run(MEM_LB, 32'h0000_0101, 32'h0, 32'h0000_8000, 5'd5, 1'b1, 0, 0, 1'b0);
    check("lb_result", seen_result, 32'hFFFF_FF80);
    run(MEM_LBU, 32'h0000_0101, 32'h0, 32'h0000_8000, 5'd5, 1'b1, 1, 2, 1'b0);
    check("lbu_result", seen_result, 32'h0000_0080);
    run(MEM_LH, 32'h0000_0102, 32'h0, 32'h8001_0000, 5'd6, 1'b1, 0, 1, 1'b0);
    check("lh_result", seen_result, 32'hFFFF_8001);

    run(MEM_LW, 32'h0000_0006, 32'h0, 32'hCAFE_F00D, 5'd8, 1'b1, 0, 0, 1'b0);
`ifdef MEM_ALIGN_CHECK_EN
    check("lw_mis_no_req", 32'(seen_req_cnt), 32'h0);
    check("lw_mis_flag", seen_mis, 32'h1);
    check("lw_mis_wb", seen_wb, 32'h0);
`else
    check("lw_unal_addr", seen_addr, 32'h0000_0004);
    check("lw_unal_result", seen_result, 32'hCAFE_F00D);
`endif

    run(MEM_LW, 32'h0000_0040, 32'h0, 32'h1234_5678, 5'd10, 1'b1, 2, 1, 1'b1);
    check("stray_rvalid_result", seen_result, 32'h1234_5678);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : $urandom;
      run(mem_op_t'($urandom_range(0, 8)), a, $urandom, $urandom, 5'($urandom),
          1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
      idle($urandom_range(0, 2));
    end

    reset_mid(3, 1);
    reset_mid(0, 2);
    idle(2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Parametrised MEM-stage controller for the 32-bit MIPS pipeline, sitting between EX/MEM and MEM/WB. Accepts one memory operation at a time over a valid/ready handshake, drives a request/grant/response data-memory port with byte enables, and returns load data sign- or zero-extended to the writeback stage. Supports byte, halfword and word loads and stores, variable memory latency, and pass-through of non-memory instructions.

## Interface
- `ADDR_W`, 32: byte address width on both sides.
- `REG_IDX_W`, 5: destination register index width.
- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  EX/MEM holds a valid instruction.
- `in_ready`  out  1  stage can accept; transfer when `in_valid & in_ready`.
- `mem_op`  in  `mem_op_t`  NONE, LB, LBU, LH, LHU, LW, SB, SH, SW.
- `addr`  in  ADDR_W  ALU result: byte address, or pass-through value for NONE.
- `store_data`  in  32  rt value for stores.
- `rd_in`  in  REG_IDX_W  destination register.
- `wb_en_in`  in  1  instruction writes a register.
- `out_valid`  out  1  one-cycle pulse, result for MEM/WB.
- `result`  out  32  extended load data or pass-through `addr`.
- `rd_out`  out  REG_IDX_W  registered `rd_in`.
- `wb_en_out`  out  1  write enable to writeback.
- `misalign`  out  1  misaligned access flagged with `out_valid`.
- `dm_req`  out  1  memory request.
- `dm_we`  out  1  1 = write.
- `dm_be`  out  4  byte enables.
- `dm_addr`  out  ADDR_W  word-aligned address, bits [1:0] = 0.
- `dm_wdata`  out  32  lane-replicated store data.
- `dm_gnt`  in  1  request accepted this cycle.
- `dm_rvalid`  in  1  read data valid.
- `dm_rdata`  in  32  read data.

## Operation
- FSM: IDLE, REQ, WAIT_R, RESP.
- IDLE: `in_ready` = 1. On transfer, register op, addr, data, rd, wb_en. NONE or trapped misalign goes to RESP; otherwise REQ.
- REQ: `dm_req` = 1 with stable `dm_we/dm_be/dm_addr/dm_wdata` until `dm_gnt`. On grant, stores go to RESP and loads go to WAIT_R.
- WAIT_R: wait for `dm_rvalid`, capture the extended lane, then RESP. `dm_rvalid` outside WAIT_R is ignored.
- RESP: `out_valid` = 1 for one cycle, then IDLE. Writeback cannot back-pressure.
- Lanes are little-endian, with lane = `addr[1:0]`.
  - SB: `be = 4'b0001 << lane`, `wdata = {4{store_data[7:0]}}`.
  - SH: `be = 4'b0011 << {addr[1],0}`, `wdata = {2{store_data[15:0]}}`.
  - SW: `be = 4'hF`.
  - Loads drive `be = 4'hF`.
- LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- `wb_en_out` = `wb_en_in` for loads and NONE; 0 for stores and on misalign.
- Reset, including mid-operation: state IDLE, `dm_req` = 0 immediately, all outputs 0, in-flight access abandoned. The memory shares `rst_n`.

## Timing
- NONE: accept at edge E0, `out_valid` in the cycle after E0, i.e. latency 1, one instruction every 2 cycles.
- Store with zero-wait grant: `dm_req` in cycle 1, `out_valid` in cycle 2.
- Load with grant in cycle 1 and `dm_rvalid` in cycle 2: `out_valid` in cycle 3. Each grant or rvalid wait cycle adds 1.
- `dm_rvalid` is never asserted in the cycle of `dm_gnt`.
- `in_ready` = 0 in REQ, WAIT_R and RESP.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - LW/SW with `addr[1:0] != 0`, or LH/LHU/SH with `addr[0] = 1`, issue no memory request.
  - `out_valid` follows 1 cycle later with `misalign` = 1, `wb_en_out` = 0, `result` = 0.
- `MEM_ALIGN_CHECK_EN` undefined:
  - `misalign` is tied 0.
  - Halfword lane uses `addr[1]` only; word ignores `addr[1:0]`. This silently aligns down.

## Structure
- Shared `structures` package holds `mem_op_t` (extended with LB, LBU, LH, LHU, SB, SH), `mem_state_t` and the lane-width constants.
- One sub-module, `mem_lane_align`: combinational store steering (`be`/`wdata`) and load extraction/extension.

## Test plan
- NONE, `addr` = 0x1234: `out_valid` 1 cycle after accept, `result` = 0x1234, `dm_req` never asserted.
- SB at 0x103, `store_data` = 0xAB, grant after 2 wait cycles: `dm_be` = 4'b1000, `dm_addr` = 0x100, `dm_wdata` = 0xABABABAB, held stable, `wb_en_out` = 0.
- LB at 0x101 with `dm_rdata` = 0x0000_8000: `result` = 0xFFFFFF80. LBU at the same address gives 0x80. LH at 0x102 with `dm_rdata` = 0x8001_0000 gives 0xFFFF8001.
- LW at 0x006 with macro defined: no `dm_req`, `misalign` = 1, `wb_en_out` = 0. Without the macro: `dm_addr` = 0x004 and normal load.
- Stray `dm_rvalid` during REQ is ignored; data is taken only from the later rvalid in WAIT_R.
- `rst_n` low during WAIT_R: `dm_req`/`out_valid` drop at once. After release, `in_ready` = 1 and a new LW completes normally.
